// File: rtl/bcd_display_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_mux_pkg
//  Description : Shared types and constants for the 3-digit multiplexed
//                7-segment driver (scan states, segment patterns, anodes).
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_display_mux_pkg;

    // Scan phase: one state per displayed digit
    typedef enum logic [1:0] {
        S0 = 2'd0,   // units
        S1 = 2'd1,   // tens
        S2 = 2'd2    // hundreds
    } state_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Active-high one-hot anode selects, bit order {hundreds,tens,units}
    localparam logic [2:0] AN_UNITS    = 3'b001;
    localparam logic [2:0] AN_TENS     = 3'b010;
    localparam logic [2:0] AN_HUNDREDS = 3'b100;
    localparam logic [2:0] AN_NONE     = 3'b000;

    // Anode belonging to a scan phase (active-high)
    function automatic logic [2:0] phase_anode(input state_t s);
        logic [2:0] a;
        a = AN_NONE;
        case (s)
            S0:      a = AN_UNITS;
            S1:      a = AN_TENS;
            S2:      a = AN_HUNDREDS;
            default: a = AN_NONE;
        endcase
        return a;
    endfunction

    // Scan order units -> tens -> hundreds -> units; any stray code recovers to S0
    function automatic state_t next_state(input state_t s);
        state_t n;
        n = S0;
        case (s)
            S0:      n = S1;
            S1:      n = S2;
            S2:      n = S0;
            default: n = S0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_display_mux_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg7
//  Description : Combinational BCD to active-high 7-segment pattern decoder.
//                Codes 10..15 are not decimal digits and show a dash.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import bcd_display_mux_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pat
);

    // Table lookup of the digit pattern, dash for non-BCD codes
    always_comb begin
        pat = SEG_DASH;
        case (bcd)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bcd_display_mux.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_mux
//  Description : Time-multiplexed 3-digit 7-segment driver. Snapshots the
//                BCD digits once per frame, scans one digit per phase with a
//                dead time at the start of each phase, optionally blanks
//                leading zeros, and drives registered segment/anode lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_mux
    import bcd_display_mux_pkg::*;
#(
    parameter int DIV            = 1000,
    parameter int GAP            = 8,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic       hold,
    input  logic       lzb,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done
);

    // Prescaler width; at least one bit so the counter always exists
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GAP  = CW'(GAP);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // XOR masks turning active-high patterns into pin polarity
    localparam logic [6:0] SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [2:0] AN_MASK  = (AN_ACTIVE_LOW  != 0) ? 3'h7  : 3'h0;

    logic [CW-1:0] cnt;
    state_t        state;
    logic [3:0]    snap0;
    logic [3:0]    snap1;
    logic [3:0]    snap2;

    logic          tick;
    logic          digit_on;
    logic          blank;
    logic          show;
    logic [3:0]    digit;
    logic [6:0]    pat;
    logic [6:0]    seg_next;
    logic [2:0]    an_next;

    assign tick = (cnt == CNT_LAST);

    // Dead time: the phase digit is lit only once the prescaler reaches GAP
    generate
        if (GAP == 0) begin : g_no_gap
            assign digit_on = 1'b1;
        end else begin : g_gap
            assign digit_on = (cnt >= CNT_GAP);
        end
    endgenerate

    // Select the snapshot digit belonging to the current scan phase
    always_comb begin
        digit = snap0;
        case (state)
            S0:      digit = snap0;
            S1:      digit = snap1;
            S2:      digit = snap2;
            default: digit = snap0;
        endcase
    end

    // Leading-zero blanking on the frozen snapshot; units always shows
    always_comb begin
        blank = 1'b0;
        if (lzb) begin
            case (state)
                S2:      blank = (snap2 == 4'd0);
                S1:      blank = (snap2 == 4'd0) && (snap1 == 4'd0);
                default: blank = 1'b0;
            endcase
        end
    end

    bcd_to_seg7 u_bcd_to_seg7 (
        .bcd (digit),
        .pat (pat)
    );

    // A blanked or dead-time digit keeps both anode and segments off
    always_comb begin
        show     = digit_on && !blank;
        seg_next = (show ? pat : SEG_OFF) ^ SEG_MASK;
        an_next  = (show ? phase_anode(state) : AN_NONE) ^ AN_MASK;
    end

    // Scan FSM: prescaler, phase advance, frame snapshot and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            state      <= S0;
            snap0      <= 4'd0;
            snap1      <= 4'd0;
            snap2      <= 4'd0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF ^ SEG_MASK;
            an         <= AN_NONE ^ AN_MASK;
        end else begin
            seg        <= seg_next;
            an         <= an_next;
            frame_done <= 1'b0;
            if (tick) begin
                cnt   <= '0;
                state <= next_state(state);
                if (state == S2) begin
                    // End of frame: pulse regardless of hold, refresh digits unless frozen
                    frame_done <= 1'b1;
                    if (!hold) begin
                        snap0 <= d0;
                        snap1 <= d1;
                        snap2 <= d2;
                    end
                end
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
- Time-multiplexed 3-digit 7-segment driver.
- Sits directly downstream of the 0–999 BCD counter and consumes its three BCD digits: units, tens and hundreds.
- Snapshots the digits once per scan frame, so a frame is never torn mid-count.
- Scans one digit per phase with an anti-ghost dead time, optionally blanks leading zeros, and drives registered segment and anode lines for the board display.

Parameters:
- DIV, 1000: clocks per digit phase; legal range ≥ 2.
- GAP, 8: dead-time clocks at the start of each phase with all anodes off; legal range 0 ≤ GAP < DIV.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment is driven as 0.
- AN_ACTIVE_LOW, 1: 1 means the selected anode is driven as 0.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- d0  in  4  units BCD digit.
- d1  in  4  tens BCD digit.
- d2  in  4  hundreds BCD digit.
- hold  in  1  1 means freeze the displayed value (snapshot suppressed).
- lzb  in  1  1 means leading-zero blanking enabled.
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW.
- an  out  3  anodes {hundreds,tens,units}, polarity set by AN_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse at the end of each scan frame.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=S0, cnt=0, snap0..2=0, frame_done=0.
  - All anodes off and all segments off, at the chosen polarity.
- Prescaler:
  - cnt counts 0..DIV-1 every clock.
  - tick = (cnt==DIV-1); on tick, cnt wraps to 0.
- FSM states S0 (units), S1 (tens), S2 (hundreds).
  - Advances only on tick: S0→S1→S2→S0.
  - Frame length = 3·DIV clocks.
- Snapshot:
  - On the tick in S2, if hold=0, snap0..2 ← d0..d2.
  - With hold=1, snap is unchanged.
  - frame_done is registered and high for exactly the one cycle after the S2 tick edge, independent of hold.
- Digit enable:
  - Phase digit is on only when cnt ≥ GAP.
  - GAP=0 means no dead time.
- Leading-zero blanking (lzb=1):
  - Hundreds is blanked when snap2==0.
  - Tens is blanked when snap2==0 and snap1==0.
  - Units is never blanked.
  - A blanked digit keeps its anode off and segments off.
- Decode:
  - Values 0–9 use standard patterns; active-high 0=3F, 1=06, 7=07, 8=7F.
  - Invalid values 10–15 display a dash (g only; active-high 40).
- Outputs:
  - seg and an are registered.
  - They reflect state/cnt/snap of the previous cycle (1-clock latency).
  - At most one anode is active at any time.
- Inputs d0..d2, hold and lzb are sampled only at the S2 tick or combinationally into registered outputs.
  - They are treated as synchronous to clk.
- Reset mid-frame forces the full reset state immediately; scanning restarts at S0 with cnt=0 after release.
- hold asserted across many frames keeps the last snapshot indefinitely. frame_done keeps pulsing every 3·DIV clocks.

Decomposition:
- Shared package holds:
  - the state typedef (S0, S1, S2, 2-bit);
  - active-high segment constants SEG_0..SEG_9 and SEG_DASH;
  - the 3-bit anode one-hot constants.
- One sub-module: bcd_to_seg7, combinational, 4-bit in → 7-bit active-high pattern.
  - Polarity inversion and blanking stay in bcd_display_mux.

Test Plan:
- Use DIV=4, GAP=1 and both polarity parameters =1 in all scenarios.
1. Reset, then hold rstn=0 for 3 cycles:
   - an=111, seg=7F, frame_done=0 throughout.
   - After release, the first units phase drives an=110 from cycle 3 (GAP + 1-clock latency), with seg=40 (digit "0").
2. d2=1, d1=2, d0=3, lzb=0, run 2 frames:
   - From the second frame on, each phase outputs: units an=110 with pattern for 3; tens an=101 with pattern for 2; hundreds an=011 with seg=79.
   - frame_done pulses every 12 cycles.
3. d2=0, d1=0, d0=7, lzb=1:
   - Hundreds and tens phases: an=111, seg=7F.
   - Units phase: seg=78.
   - With d1=5 instead, the tens digit shows and hundreds stays blank.
4. Snapshot coherence: change d0 from 4 to 9 mid-frame during S1:
   - Units keep showing 4 until after the next S2 tick, then show 9.
5. hold=1, then change all digits to 8 for 3 frames:
   - Display unchanged and frame_done still pulses 3 times.
   - Drop hold: seg=00 appears on every digit after the next S2 tick.
6. d0=12:
   - Units show the dash (seg=3F).
   - An rstn pulse during S1 returns an=111 immediately, and scanning restarts at S0.
